bcd_ascii_streamer: RTL and testbench



---
 rtl/bcd_ascii_streamer.sv | 101 ++++++++++
 tb/tb_bcd_ascii_streamer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bcd_ascii_streamer.sv
// bcd_ascii_streamer: packed BCD to ASCII byte stream with sign, zero suppression and grouping
module bcd_ascii_streamer #(
  parameter int NDIG = 43,
  parameter bit SEP_EN = 1'b0,
  parameter logic [7:0] SEP_CHAR = 8'h2C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              neg,
  input  logic [4*NDIG-1:0] bcd,
  output logic              busy,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [7:0]        o_char,
  output logic              o_last,
  output logic              err
);
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [2:0] {IDLE, SCAN, SIGN, DIG, SEP} state_t;
  state_t state, n_state;
  logic [4*NDIG-1:0] data, n_data;
  logic neg_r, n_neg, n_busy, n_valid, n_last, n_err;
  logic [7:0] n_char;
  logic [IW-1:0] idx, n_idx, msd, k;
  logic [3:0] nd;
  always_comb begin
    msd = '0;
    for (int i = 0; i < NDIG; i++) if (data[4*i +: 4] != 4'd0) msd = IW'(i);
  end
  // k is the digit index of whichever character gets loaded next
  assign k  = state == SCAN ? msd : state == SIGN ? idx : idx - 1'b1;
  assign nd = data[4*k +: 4];
  always_comb begin
    n_state = state;
    n_data  = data;
    n_neg   = neg_r;
    n_idx   = idx;
    n_busy  = busy;
    n_valid = o_valid;
    n_char  = o_char;
    n_last  = o_last;
    n_err   = err;
    if (state == IDLE) begin
      if (ld) begin
        n_data  = bcd;
        n_neg   = neg;
        n_err   = 1'b0;
        n_busy  = 1'b1;
        n_state = SCAN;
      end
    end else if (state == SCAN && neg_r) begin
      n_idx   = msd;
      n_valid = 1'b1;
      n_char  = 8'h2D;
      n_last  = 1'b0;
      n_state = SIGN;
    end else if (state == SCAN || o_ready) begin
      if (state == DIG && idx == '0) begin
        n_valid = 1'b0;
        n_last  = 1'b0;
        n_busy  = 1'b0;
        n_state = IDLE;
      end else if (state == DIG && SEP_EN && 32'(idx) % 3 == 0) begin
        n_char  = SEP_CHAR;
        n_last  = 1'b0;
        n_state = SEP;
      end else begin
        n_idx   = k;
        n_valid = 1'b1;
        n_char  = nd > 4'd9 ? 8'h3F : {4'h3, nd};
        n_last  = k == '0;
        n_err   = err | (nd > 4'd9);
        n_state = DIG;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      data    <= '0;
      neg_r   <= 1'b0;
      idx     <= '0;
      busy    <= 1'b0;
      o_valid <= 1'b0;
      o_char  <= 8'h00;
      o_last  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= n_state;
      data    <= n_data;
      neg_r   <= n_neg;
      idx     <= n_idx;
      busy    <= n_busy;
      o_valid <= n_valid;
      o_char  <= n_char;
      o_last  <= n_last;
      err     <= n_err;
    end
  end
endmodule

// File: tb/tb_bcd_ascii_streamer.sv
// tb_bcd_ascii_streamer: scoreboard bench driving ungrouped (u0) and grouped (u1) streamers in lockstep
module tb_bcd_ascii_streamer;
  localparam int NDIG = 43;
  typedef struct packed { logic [7:0] c; logic l; } exp_t;
  logic clk = 1'b0, rst = 1'b1, ld = 1'b0, neg = 1'b0, o_ready = 1'b1;
  logic [4*NDIG-1:0] bcd = '0;
  logic [1:0] busy, vld, lst, er;
  logic [7:0] ch [2];
  exp_t q [2][$];
  int errors = 0, checks = 0, rmode = 0;
  always #5 clk = ~clk;
  bcd_ascii_streamer #(.NDIG(NDIG), .SEP_EN(1'b0)) u0 (.clk(clk), .rst(rst), .ld(ld), .neg(neg), .bcd(bcd),
    .busy(busy[0]), .o_valid(vld[0]), .o_ready(o_ready), .o_char(ch[0]), .o_last(lst[0]), .err(er[0]));
  bcd_ascii_streamer #(.NDIG(NDIG), .SEP_EN(1'b1)) u1 (.clk(clk), .rst(rst), .ld(ld), .neg(neg), .bcd(bcd),
    .busy(busy[1]), .o_valid(vld[1]), .o_ready(o_ready), .o_char(ch[1]), .o_last(lst[1]), .err(er[1]));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // sink readiness: 0 always ready, 1 random with multi-cycle stalls, 2 never ready
  initial forever begin
    @(posedge clk);
    #1;
    o_ready = rmode == 0 ? 1'b1 : rmode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
  end
  for (genvar g = 0; g < 2; g++) begin : mon
    logic ps = 1'b0, pl;
    logic [7:0] pc;
    exp_t e;
    always @(negedge clk) begin
      if (rst) ps = 1'b0;
      else begin
        if (ps) begin
          chk($sformatf("u%0d stall valid", g), int'(vld[g]), 1);
          chk($sformatf("u%0d stall char", g), int'(ch[g]), int'(pc));
          chk($sformatf("u%0d stall last", g), int'(lst[g]), int'(pl));
        end
        ps = vld[g] && !o_ready;
        pc = ch[g];
        pl = lst[g];
        if (vld[g] && o_ready) begin
          if (q[g].size() == 0) chk($sformatf("u%0d unexpected char", g), int'(ch[g]), -1);
          else begin
            e = q[g].pop_front();
            chk($sformatf("u%0d char", g), int'(ch[g]), int'(e.c));
            chk($sformatf("u%0d last", g), int'(lst[g]), int'(e.l));
          end
        end
      end
    end
  end
  task automatic issue(input logic [4*NDIG-1:0] v, input logic n, input string s0, input string s1);
    for (int i = 0; i < s0.len(); i++) q[0].push_back('{s0[i], i == s0.len() - 1});
    for (int i = 0; i < s1.len(); i++) q[1].push_back('{s1[i], i == s1.len() - 1});
    bcd = v;
    neg = n;
    ld = 1'b1;
    cyc();
    ld = 1'b0;
    chk("ld busy", int'(busy), 3);
    chk("ld err clear", int'(er), 0);
    chk("scan no valid", int'(vld), 0);
    cyc();
    chk("first valid", int'(vld), 3);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((busy != 0 || vld != 0) && n < 400) begin
      cyc();
      n++;
    end
    chk("idle timeout", int'(n < 400), 1);
    chk("u0 drained", q[0].size(), 0);
    chk("u1 drained", q[1].size(), 0);
  endtask
  initial begin
    string a0, a1;
    repeat (2) cyc();
    chk("rst busy", int'(busy), 0);
    chk("rst valid", int'(vld), 0);
    chk("rst char", int'(ch[0]), 0);
    chk("rst last", int'(lst), 0);
    chk("rst err", int'(er), 0);
    rst = 1'b0;
    cyc();
    issue(172'h123, 1'b0, "123", "123");
    cyc();
    chk("busy mid", int'(busy), 3);
    cyc();
    chk("busy before last", int'(busy), 3);
    cyc();
    chk("busy after last", int'(busy), 0);
    wait_idle();
    issue(172'h0, 1'b0, "0", "0");
    wait_idle();
    issue(172'h0, 1'b1, "-0", "-0");
    wait_idle();
    issue(172'h1234567, 1'b1, "-1234567", "-1,234,567");
    wait_idle();
    rmode = 1;
    issue(172'h1234567, 1'b1, "-1234567", "-1,234,567");
    wait_idle();
    issue(172'h98765, 1'b0, "98765", "98,765");
    wait_idle();
    rmode = 0;
    cyc();
    issue(172'h1A3, 1'b0, "1?3", "1?3");
    wait_idle();
    chk("err sticky", int'(er), 3);
    issue(172'h456, 1'b0, "456", "456");
    wait_idle();
    chk("err stays clear", int'(er), 0);
    issue(172'h98765, 1'b0, "98765", "98,765");
    bcd = 172'h111;
    neg = 1'b1;
    ld = 1'b1;
    cyc();
    ld = 1'b0;
    wait_idle();
    issue(172'h9A99999, 1'b0, "9?99999", "9,?99,999");
    cyc();
    rmode = 2;
    repeat (2) cyc();
    chk("pre-rst err", int'(er), 3);
    chk("pre-rst busy", int'(busy), 3);
    rst = 1'b1;
    cyc();
    chk("mid rst valid", int'(vld), 0);
    chk("mid rst busy", int'(busy), 0);
    chk("mid rst err", int'(er), 0);
    rst = 1'b0;
    q[0].delete();
    q[1].delete();
    rmode = 0;
    repeat (3) cyc();
    chk("post rst quiet", int'(vld), 0);
    issue(172'h2048, 1'b0, "2048", "2,048");
    wait_idle();
    a0 = "";
    a1 = "";
    for (int i = NDIG - 1; i >= 0; i--) begin
      a0 = {a0, "1"};
      a1 = {a1, "1"};
      if (i % 3 == 0 && i != 0) a1 = {a1, ","};
    end
    issue({NDIG{4'h1}}, 1'b0, a0, a1);
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
